inst_sram_resp: RTL
===================

Name: inst_sram_resp

Overview:
- Responder end of the sram-like instruction port that the fetch stage drives: sram_en / sram_we / sram_addr / sram_wdata in, sram_rdata out.
- Fixed 1-cycle read latency: data for a request enabled in cycle N is valid on sram_rdata in cycle N+1.
- Backs a word-addressed memory window starting at BASE_ADDR.
- Supports byte-masked writes for preload/self-modifying tests, and flags out-of-window and misaligned accesses for debug.

Parameters:
- ADDR_BITS, 12, log2 of window depth in 32-bit words (default 4096 words = 16 KiB).
- BASE_ADDR, 32'h1c000000, byte address of word 0; must be 4-byte aligned.
- FILL_DATA, 32'h03400000, value returned for out-of-window reads (LoongArch nop).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- sram_en  input  1  request valid this cycle.
- sram_we  input  4  byte write enables; bit i writes wdata[8i+7:8i]; 0 = read.
- sram_addr  input  32  byte address.
- sram_wdata  input  32  write data.
- sram_rdata  output  32  read data, registered; valid the cycle after an enabled request.
- err_oob  output  1  sticky: an enabled access fell outside the window.
- err_misalign  output  1  sticky: an enabled access had addr[1:0] != 0.
- err_addr  output  32  sram_addr of the first access that set either error flag.
- err_clr  input  1  clears err_oob, err_misalign and err_addr next cycle.

Behaviour:
- Reset (clk edge with reset=1):
  - sram_rdata <= 0; err_oob, err_misalign <= 0; err_addr <= 0.
  - Memory array is not cleared.
  - sram_en is ignored: no write, no read update.
- Decode:
  - off = sram_addr - BASE_ADDR, computed mod 2^32.
  - in_win = (off >> 2) < 2^ADDR_BITS; this makes addresses below BASE_ADDR out of window through wraparound.
  - Word index = off[ADDR_BITS+1:2]; addr[1:0] is ignored for indexing.
- Enabled cycle (sram_en=1, reset=0):
  - In window: sram_rdata <= mem[idx] (read-first: old contents, even if the same cycle writes that word). Each byte i with we[i]=1 gets mem[idx].byte_i <= wdata byte_i.
  - Out of window: sram_rdata <= FILL_DATA; no write occurs; err_oob <= 1.
  - addr[1:0] != 0: err_misalign <= 1. The access still proceeds using the aligned word.
- Idle cycle (sram_en=0): sram_rdata holds its previous value, so the fetch stage may sample late while stalled; no memory change.
- Error capture:
  - err_addr loads sram_addr only when an error condition occurs while both flags are currently 0. A later error does not overwrite it.
  - err_clr=1 clears both flags and err_addr, and takes priority over a simultaneous new error.
  - After err_clr, the next error captures its address again.
- Throughput: one access per cycle, back-to-back, no stalls, no ready signal.
- Address wrap: BASE_ADDR + 4*2^ADDR_BITS - 4 is the last valid word. The next word up is out of window; it does not alias to word 0.
- Reset asserted while sram_en=1 with a nonzero we: the write is dropped.

Optional Feature:
- Macro: INST_SRAM_STAT_EN.
- Defined: adds three ports:
  - stat_clr  input  1
  - rd_cnt  output  32
  - wr_cnt  output  32
- Counting rules when defined:
  - Each enabled cycle with we==0 increments rd_cnt; with we!=0 increments wr_cnt. Out-of-window accesses are included.
  - Counters wrap at 2^32.
  - Both counters reset to 0 on reset. stat_clr zeroes them next cycle and takes priority over a same-cycle increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Read latency/hold:
  - Stimulus: preload mem[0]=32'h12345678; en=1, we=0, addr=32'h1c000000, then en=0 for 3 cycles.
  - Required: rdata=32'h12345678 from the cycle after the request, held for all 3 idle cycles.
- Byte write, read-first:
  - Stimulus: mem[1]=32'hAABBCCDD; en=1, we=4'b0101, wdata=32'h11223344, addr=32'h1c000004; then read 32'h1c000004.
  - Required: first rdata=32'hAABBCCDD; second rdata=32'hAA22CC44.
- Out of window:
  - Stimulus: read 32'h1c004000, then read 32'h1bfffffc.
  - Required: rdata=32'h03400000 both times; err_oob=1; err_addr=32'h1c004000 (not overwritten by the second access).
- Misaligned + clear:
  - Stimulus: read 32'h1c000006, then err_clr=1 for one cycle.
  - Required: returns word 1; err_misalign=1, err_addr=32'h1c000006; after the err_clr cycle both flags and err_addr are 0.
- Reset mid-write:
  - Stimulus: reset=1 while en=1, we=4'hF, wdata=32'hDEADBEEF, addr=32'h1c000008; then read 32'h1c000008.
  - Required: rdata=0 after reset; the read returns the pre-reset contents of word 2, not 32'hDEADBEEF.
- INST_SRAM_STAT_EN:
  - Stimulus: 3 reads and 2 writes back-to-back, then stat_clr=1 in the same cycle as a read.
  - Required: rd_cnt=3, wr_cnt=2 before the clear; both 0 after it.

Source files
------------

// File: rtl/inst_sram_resp.sv
// rtl/inst_sram_resp.sv - 1-cycle-latency instruction SRAM responder with byte writes and sticky error capture
// Optional INST_SRAM_STAT_EN adds read/write access counters (stat_clr, rd_cnt, wr_cnt).
module inst_sram_resp #(
    parameter int          ADDR_BITS = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000,
    parameter logic [31:0] FILL_DATA = 32'h03400000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        err_oob,
    output logic        err_misalign,
    output logic [31:0] err_addr,
`ifdef INST_SRAM_STAT_EN
    input  logic        stat_clr,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
`endif
    input  logic        err_clr
);

    logic [31:0]          mem [0:(2**ADDR_BITS)-1];
    logic [31:0]          off;
    logic [ADDR_BITS-1:0] idx;
    logic                 in_win;
    logic                 misalign;
    logic                 hit_oob;
    logic                 hit_mis;

    // Addresses below BASE_ADDR wrap to huge offsets and so fall out of window.
    always_comb begin
        off      = sram_addr - BASE_ADDR;
        idx      = off[ADDR_BITS+1:2];
        in_win   = (off[31:ADDR_BITS+2] == '0);
        misalign = (off[1:0] != 2'b00);
        hit_oob  = sram_en && !in_win;
        hit_mis  = sram_en && misalign;
    end

    // Array has no reset so preloaded contents survive a core reset.
    always_ff @(posedge clk) begin
        if (!reset && sram_en && in_win) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_we[i]) begin
                    mem[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sram_rdata <= 32'h0;
        end else if (sram_en) begin
            sram_rdata <= in_win ? mem[idx] : FILL_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            err_oob      <= 1'b0;
            err_misalign <= 1'b0;
            err_addr     <= 32'h0;
        end else begin
            if ((hit_oob || hit_mis) && !err_oob && !err_misalign) begin
                err_addr <= sram_addr;
            end
            err_oob      <= err_oob | hit_oob;
            err_misalign <= err_misalign | hit_mis;
        end
    end

`ifdef INST_SRAM_STAT_EN
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            rd_cnt <= 32'h0;
            wr_cnt <= 32'h0;
        end else if (sram_en) begin
            if (sram_we == 4'h0) begin
                rd_cnt <= rd_cnt + 32'd1;
            end else begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
